// File: rtl/router_reg_pkg.sv
// Shared types, header field layout and small helpers for the router register stage.
package router_reg_pkg;

  localparam int DATA_WIDTH = 8;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = DATA_WIDTH - 1;

  // Destination 3 does not exist on a 1x3 router
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef logic [DATA_WIDTH-1:0] byte_t;

  typedef struct packed {
    logic [LEN_MSB-LEN_LSB:0]   len;
    logic [ADDR_MSB-ADDR_LSB:0] addr;
  } hdr_t;

  function automatic logic addr_valid(input byte_t b);
    return (b[ADDR_MSB:ADDR_LSB] != ADDR_INVALID);
  endfunction

  function automatic byte_t parity_fold(input byte_t acc, input byte_t b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/router_reg_if.sv
// Byte stream, FSM state strobes and status returns between router_fsm, source and router_reg.
interface router_reg_if
  import router_reg_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) ();

  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic          fifo_full;
  logic          detect_add;
  logic          lfd_state;
  logic          ld_state;
  logic          laf_state;
  logic          full_state;
  logic          rst_int_reg;
  logic          parity_done;
  logic          low_pkt_valid;
  logic          err;
  logic [DW-1:0] dout;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  parity_done, low_pkt_valid, err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output parity_done, low_pkt_valid, err, dout
  );

endinterface

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, payload staging toward the FIFO,
// byte hold across a full FIFO, and running/received parity comparison.
module router_reg
  import router_reg_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  router_reg_if.slave  bus
);

  byte_t dout_r;
  byte_t hdr_byte_r;
  byte_t hold_byte_r;
  byte_t int_parity_r;
  byte_t pkt_parity_r;
  logic  parity_done_r;
  logic  parity_done_d_r;
  logic  low_pkt_valid_r;
  logic  err_r;

  logic  latch_hdr_s;
  logic  latch_hold_s;
  logic  load_data_s;
  logic  par_data_s;
  logic  par_hold_s;
  logic  cap_data_s;
  logic  cap_hold_s;
  logic  err_eval_s;
  logic  lpv_set_s;

  byte_t dout_nxt_s;
  byte_t hdr_byte_nxt_s;
  byte_t hold_byte_nxt_s;
  byte_t int_parity_nxt_s;
  byte_t pkt_parity_nxt_s;
  logic  parity_done_nxt_s;
  logic  low_pkt_valid_nxt_s;
  logic  err_nxt_s;

  // Decode FSM strobes into per-register update conditions
  always_comb begin
    latch_hdr_s  = 1'b0;
    latch_hold_s = 1'b0;
    load_data_s  = 1'b0;
    par_data_s   = 1'b0;
    par_hold_s   = 1'b0;
    cap_data_s   = 1'b0;
    cap_hold_s   = 1'b0;
    err_eval_s   = 1'b0;
    lpv_set_s    = 1'b0;

    latch_hdr_s  = bus.detect_add & bus.pkt_valid & addr_valid(bus.data_in);
    latch_hold_s = bus.ld_state & bus.fifo_full;
    load_data_s  = bus.ld_state & ~bus.fifo_full;
    lpv_set_s    = bus.ld_state & ~bus.pkt_valid;
    par_data_s   = load_data_s & bus.pkt_valid;
    par_hold_s   = bus.laf_state & ~low_pkt_valid_r;
    cap_data_s   = load_data_s & ~bus.pkt_valid;
    // A held byte seen while low_pkt_valid is up is the parity byte itself
    cap_hold_s   = bus.laf_state & low_pkt_valid_r & ~parity_done_r;
    err_eval_s   = parity_done_r & ~parity_done_d_r;
  end

  // Next-state values for the byte-wide datapath registers
  always_comb begin
    dout_nxt_s      = dout_r;
    hdr_byte_nxt_s  = hdr_byte_r;
    hold_byte_nxt_s = hold_byte_r;

    if (bus.lfd_state) begin
      dout_nxt_s = hdr_byte_r;
    end else if (load_data_s) begin
      dout_nxt_s = bus.data_in;
    end else if (bus.laf_state) begin
      dout_nxt_s = hold_byte_r;
    end else if (bus.full_state) begin
      dout_nxt_s = dout_r;
    end else begin
      dout_nxt_s = dout_r;
    end

    if (latch_hdr_s) begin
      hdr_byte_nxt_s = bus.data_in;
    end else begin
      hdr_byte_nxt_s = hdr_byte_r;
    end

    if (latch_hold_s) begin
      hold_byte_nxt_s = bus.data_in;
    end else begin
      hold_byte_nxt_s = hold_byte_r;
    end
  end

  // Next-state values for parity tracking and status flags
  always_comb begin
    int_parity_nxt_s    = int_parity_r;
    pkt_parity_nxt_s    = pkt_parity_r;
    parity_done_nxt_s   = parity_done_r;
    low_pkt_valid_nxt_s = low_pkt_valid_r;
    err_nxt_s           = err_r;

    if (bus.detect_add) begin
      int_parity_nxt_s = '0;
    end else if (bus.lfd_state) begin
      int_parity_nxt_s = parity_fold(int_parity_r, hdr_byte_r);
    end else if (par_data_s) begin
      int_parity_nxt_s = parity_fold(int_parity_r, bus.data_in);
    end else if (par_hold_s) begin
      int_parity_nxt_s = parity_fold(int_parity_r, hold_byte_r);
    end else begin
      int_parity_nxt_s = int_parity_r;
    end

    if (bus.detect_add) begin
      pkt_parity_nxt_s  = '0;
      parity_done_nxt_s = 1'b0;
    end else if (cap_data_s) begin
      pkt_parity_nxt_s  = bus.data_in;
      parity_done_nxt_s = 1'b1;
    end else if (cap_hold_s) begin
      pkt_parity_nxt_s  = hold_byte_r;
      parity_done_nxt_s = 1'b1;
    end else begin
      pkt_parity_nxt_s  = pkt_parity_r;
      parity_done_nxt_s = parity_done_r;
    end

    // Set wins over the FSM's clear when both arrive together
    if (lpv_set_s) begin
      low_pkt_valid_nxt_s = 1'b1;
    end else if (bus.rst_int_reg) begin
      low_pkt_valid_nxt_s = 1'b0;
    end else begin
      low_pkt_valid_nxt_s = low_pkt_valid_r;
    end

    if (bus.detect_add) begin
      err_nxt_s = 1'b0;
    end else if (err_eval_s) begin
      err_nxt_s = (int_parity_r != pkt_parity_r);
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Datapath byte registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r      <= '0;
      hdr_byte_r  <= '0;
      hold_byte_r <= '0;
    end else begin
      dout_r      <= dout_nxt_s;
      hdr_byte_r  <= hdr_byte_nxt_s;
      hold_byte_r <= hold_byte_nxt_s;
    end
  end

  // Parity and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      int_parity_r    <= '0;
      pkt_parity_r    <= '0;
      parity_done_r   <= 1'b0;
      parity_done_d_r <= 1'b0;
      low_pkt_valid_r <= 1'b0;
      err_r           <= 1'b0;
    end else begin
      int_parity_r    <= int_parity_nxt_s;
      pkt_parity_r    <= pkt_parity_nxt_s;
      parity_done_r   <= parity_done_nxt_s;
      parity_done_d_r <= parity_done_r;
      low_pkt_valid_r <= low_pkt_valid_nxt_s;
      err_r           <= err_nxt_s;
    end
  end

  assign bus.dout          = dout_r;
  assign bus.parity_done   = parity_done_r;
  assign bus.low_pkt_valid = low_pkt_valid_r;
  assign bus.err           = err_r;

endmodule

// File: tb/tb_router_reg.sv
// Scoreboard bench for router_reg: emulates router_fsm strobes per packet, predicts the
// FIFO byte stream and the parity verdict from packet contents.
module tb_router_reg;

  logic clk;
  logic rst;
  logic deliver;

  router_reg_if #(.DW(8)) bus ();

  router_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  bit         err_q [$];
  logic [7:0] pay   [0:15];
  logic [7:0] last_hdr;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of FSM behaviour; called at a negedge, returns at the next negedge
  task automatic cyc(input bit da, input bit lfd, input bit ld, input bit laf, input bit fs,
                     input bit rir, input bit pv, input bit full, input logic [7:0] din,
                     input bit dlv, input logic [7:0] exp);
    rst             = 1'b0;
    bus.detect_add  = da;
    bus.lfd_state   = lfd;
    bus.ld_state    = ld;
    bus.laf_state   = laf;
    bus.full_state  = fs;
    bus.rst_int_reg = rir;
    bus.pkt_valid   = pv;
    bus.fifo_full   = full;
    bus.data_in     = din;
    deliver         = dlv;
    if (dlv) exp_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic full_wait(input bit pv);
    int n;
    n = int'($urandom_range(0, 3));
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 1, 0, pv, 1, 8'($urandom), 0, 8'h00);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.detect_add  = 1'b0;
    bus.lfd_state   = 1'b0;
    bus.ld_state    = 1'b0;
    bus.laf_state   = 1'b0;
    bus.full_state  = 1'b0;
    bus.rst_int_reg = 1'b0;
    bus.pkt_valid   = 1'b1;
    bus.fifo_full   = 1'b0;
    bus.data_in     = 8'($urandom);
    deliver         = 1'b0;
    repeat (2) @(negedge clk);
    check8("rst_dout", bus.dout, 8'h00);
    check1("rst_parity_done", bus.parity_done, 1'b0);
    check1("rst_low_pkt_valid", bus.low_pkt_valid, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    last_hdr = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int len, input logic [15:0] full_mask,
                          input bit par_full, input bit par_ovr, input logic [7:0] par_val,
                          input int abort_at);
    logic [7:0] eff;
    logic [7:0] xr;
    logic [7:0] par;
    logic [1:0] addr;
    addr = hdr[1:0];
    eff  = (addr != 2'b11) ? hdr : last_hdr;
    last_hdr = eff;
    par = hdr;
    for (int i = 0; i < len; i++) par = par ^ pay[i];
    if (par_ovr) par = par_val;
    xr = eff;

    cyc(1, 0, 0, 0, 0, 0, 1, 0, hdr, 0, 8'h00);
    check1("err_clr_on_detect", bus.err, 1'b0);
    check1("pdone_clr_on_detect", bus.parity_done, 1'b0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'($urandom), 1, eff);

    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      xr = xr ^ pay[i];
      if (full_mask[i]) begin
        cyc(0, 0, 1, 0, 0, 0, 1, 1, pay[i], 0, 8'h00);
        full_wait(1'b1);
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 8'($urandom), 1, pay[i]);
      end else begin
        cyc(0, 0, 1, 0, 0, 0, 1, 0, pay[i], 1, pay[i]);
      end
    end

    err_q.push_back(xr != par);
    if (par_full) begin
      cyc(0, 0, 1, 0, 0, 0, 0, 1, par, 0, 8'h00);
      check1("lpv_set_full", bus.low_pkt_valid, 1'b1);
      check1("pdone_wait_full", bus.parity_done, 1'b0);
      full_wait(1'b0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0, 8'($urandom), 1, par);
    end else begin
      cyc(0, 0, 1, 0, 0, 0, 0, 0, par, 1, par);
      check1("lpv_set", bus.low_pkt_valid, 1'b1);
    end
    check1("parity_done", bus.parity_done, 1'b1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 8'($urandom), 0, 8'h00);
    check1("lpv_clr", bus.low_pkt_valid, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 8'($urandom), 0, 8'h00);
  endtask

  // Monitor: FIFO writes against the byte queue, err against the verdict queue
  initial begin : monitor
    logic [7:0] last;
    logic [7:0] e;
    bit         pd_prev;
    bit         err_due;
    bit         ev;
    last    = 8'h00;
    pd_prev = 1'b0;
    err_due = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last    = 8'h00;
        pd_prev = 1'b0;
        err_due = 1'b0;
      end else begin
        if (deliver) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dout_unexpected: got %h expected no write", bus.dout);
          end else begin
            e = exp_q.pop_front();
            check8("dout", bus.dout, e);
            last = e;
          end
        end else begin
          check8("dout_stable", bus.dout, last);
        end
        if (err_due) begin
          err_due = 1'b0;
          if (err_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL err_unexpected: got %b expected no parity event", bus.err);
          end else begin
            ev = err_q.pop_front();
            check1("err", bus.err, ev);
          end
        end
        if (bus.parity_done && !pd_prev) err_due = 1'b1;
        pd_prev = bus.parity_done;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0]  hdr;
    logic [15:0] mask;
    int          len;
    int          abort_at;
    last_hdr = 8'h00;
    deliver  = 1'b0;
    @(negedge clk);
    do_reset();

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_pkt(8'h0D, 3, 16'h0000, 1'b0, 1'b0, 8'h00, -1);   // good packet
    send_pkt(8'h0D, 3, 16'h0000, 1'b0, 1'b1, 8'hFF, -1);   // bad parity
    send_pkt(8'h0D, 3, 16'h0002, 1'b0, 1'b0, 8'h00, -1);   // full on 22
    send_pkt(8'h0D, 3, 16'h0000, 1'b1, 1'b0, 8'h00, -1);   // parity meets full
    send_pkt(8'h13, 3, 16'h0000, 1'b0, 1'b0, 8'h00, -1);   // invalid addr
    send_pkt(8'h0D, 3, 16'h0000, 1'b0, 1'b0, 8'h00, 2);    // reset mid-stream
    send_pkt(8'h17, 3, 16'h0000, 1'b0, 1'b0, 8'h00, -1);   // invalid addr after reset

    for (int p = 0; p < 60; p++) begin
      len = int'($urandom_range(1, 8));
      hdr = {6'(len), 2'($urandom_range(0, 3))};
      mask = 16'h0000;
      for (int i = 0; i < len; i++) begin
        pay[i]  = 8'($urandom);
        mask[i] = ($urandom_range(0, 3) == 0);
      end
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_pkt(hdr, len, mask, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               8'($urandom), abort_at);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL dout_queue_drain: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (err_q.size() != 0) begin
      failures++;
      $display("FAIL err_queue_drain: got %0d pending expected 0", err_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
